load_exec_unit: RTL and testbench

Load execution stage directly downstream of the load reservation station (`rs_load`). Each cycle it is idle, it picks one ready load entry (tags `ld_1`/`ld_2`/`ld_3`) using round-robin, latches that entry's effective address and issues a 64-bit read to data memory over a req/ack + rvalid handshake. It then arbitrates for the common data bus (CDB) and broadcasts the loaded value under the entry's tag. In the same cycle it frees the entry in `rs_load` through `free_tag_flag`/`free_this_tag`.

---
 rtl/tomasulo_pkg.sv | 26 ++
 rtl/rr_pick3.sv | 26 ++
 rtl/load_exec_unit.sv | 118 +++++++++++
 tb/tb_load_exec_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: reservation-station tags and the load-unit FSM states.
package tomasulo_pkg;

  localparam int unsigned TAG_W = 4;

  localparam logic [TAG_W-1:0] NOTAG  = 4'd0;
  localparam logic [TAG_W-1:0] ADD_1  = 4'd1;
  localparam logic [TAG_W-1:0] ADD_2  = 4'd2;
  localparam logic [TAG_W-1:0] ADD_3  = 4'd3;
  localparam logic [TAG_W-1:0] MULT_1 = 4'd4;
  localparam logic [TAG_W-1:0] MULT_2 = 4'd5;
  localparam logic [TAG_W-1:0] LD_1   = 4'd6;
  localparam logic [TAG_W-1:0] LD_2   = 4'd7;
  localparam logic [TAG_W-1:0] LD_3   = 4'd8;
  localparam logic [TAG_W-1:0] ST_1   = 4'd9;
  localparam logic [TAG_W-1:0] ST_2   = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StCdb,
    StBcast
  } ld_state_e;

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker. Index 0 has priority when i_ptr = 0, then 1, then 2;
// the search always starts at i_ptr and wraps. A pointer value of 3 behaves like 0.
module rr_pick3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt,
  output logic [1:0] o_idx
);

  logic [1:0] w_e;

  // Walk candidates from lowest to highest priority so the last hit (offset 0 side) wins.
  always_comb begin
    o_gnt = 3'b000;
    o_idx = 2'd0;
    w_e   = 2'd0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_e = 2'((32'(i_ptr) + 32'd2 - k) % 32'd3);
      if (i_req[w_e]) begin
        o_gnt = 3'b001 << w_e;
        o_idx = w_e;
      end
    end
  end

endmodule

// File: rtl/load_exec_unit.sv
// Load execution stage: picks a ready load entry round-robin, reads 64-bit data memory, then
// broadcasts the value on the CDB and frees the entry in rs_load in the same cycle.
module load_exec_unit
  import tomasulo_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            ready_bus,
  input  logic [3*ADDR_W-1:0]   load_addr,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  cdb_req,
  input  logic                  cdb_grant,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_id,
  output logic [DATA_W-1:0]     cdb_data,
  output logic                  free_tag_flag,
  output logic [TAG_W-1:0]      free_this_tag,
  output logic                  busy
);

  ld_state_e           r_state, w_state_next;
  logic [1:0]          r_ptr;
  logic [1:0]          r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [TAG_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_data;

  logic [2:0]          w_req;
  logic [2:0]          w_gnt;
  logic [1:0]          w_idx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_pick;
  logic                w_bcast;

  // Picker index 0 is ld_1, which sits on ready_bus bit 2.
  assign w_req  = {ready_bus[0], ready_bus[1], ready_bus[2]};
  assign w_pick = (r_state == StIdle) && (ready_bus != 3'b000);

  rr_pick3 u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // One-hot AND-OR select of the granted entry's address slice.
  always_comb begin
    w_sel_addr = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_gnt[i]) w_sel_addr = load_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Next-state logic; inputs are only honoured in the state that waits on them.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (ready_bus != 3'b000) w_state_next = StReq;
      StReq:   if (mem_ack)             w_state_next = StWait;
      StWait:  if (mem_rvalid)          w_state_next = StCdb;
      StCdb:   if (cdb_grant)           w_state_next = StBcast;
      StBcast:                          w_state_next = StIdle;
      default:                          w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address/tag/data capture and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= 2'd0;
      r_idx  <= 2'd0;
      r_addr <= '0;
      r_tag  <= TAG_W'(NOTAG);
      r_data <= '0;
    end else begin
      if (w_pick) begin
        r_addr <= w_sel_addr;
        r_idx  <= w_idx;
        r_tag  <= TAG_W'(LD_1) + TAG_W'(w_idx);
      end
      if ((r_state == StWait) && mem_rvalid) begin
        r_data <= mem_rdata;
      end
      if (r_state == StBcast) begin
        r_ptr <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end
    end
  end

  assign w_bcast       = (r_state == StBcast);
  assign busy          = (r_state != StIdle);
  assign mem_req       = (r_state == StReq);
  assign mem_addr      = mem_req ? r_addr : '0;
  assign cdb_req       = (r_state == StCdb);
  assign cdb_valid     = w_bcast;
  assign cdb_id        = w_bcast ? r_tag : TAG_W'(NOTAG);
  assign cdb_data      = w_bcast ? r_data : '0;
  assign free_tag_flag = w_bcast;
  assign free_this_tag = w_bcast ? r_tag : TAG_W'(NOTAG);

endmodule

// File: tb/tb_load_exec_unit.sv
// Self-checking bench for load_exec_unit: directed scenarios plus randomized loads, checked
// against a transaction-level model of round-robin selection and handshake timing.
module tb_load_exec_unit;

  logic          clk;
  logic          rst_n;
  logic [2:0]    ready_bus;
  logic [191:0]  load_addr;
  logic          mem_req;
  logic [63:0]   mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;
  logic          cdb_req;
  logic          cdb_grant;
  logic          cdb_valid;
  logic [3:0]    cdb_id;
  logic [63:0]   cdb_data;
  logic          free_tag_flag;
  logic [3:0]    free_this_tag;
  logic          busy;

  int checks;
  int errors;
  int m_ptr;       // model: entry (0=ld_1) where the next search starts
  int last_tag;    // model: tag broadcast by the most recent load

  load_exec_unit #(
    .ADDR_W (64),
    .DATA_W (64),
    .TAG_W  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ready_bus     (ready_bus),
    .load_addr     (load_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .cdb_req       (cdb_req),
    .cdb_grant     (cdb_grant),
    .cdb_valid     (cdb_valid),
    .cdb_id        (cdb_id),
    .cdb_data      (cdb_data),
    .free_tag_flag (free_tag_flag),
    .free_this_tag (free_this_tag),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // First ready entry at or after the pointer, wrapping; ld_1 is ready bit 2.
  function automatic int model_pick(input logic [2:0] rdy, input int ptr);
    for (int k = 0; k < 3; k++) begin
      int e;
      e = (ptr + k) % 3;
      if (rdy[2-e]) return e;
    end
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_mreq"}, 64'(mem_req), 64'd0);
    check_eq({tag, "_maddr"}, mem_addr, 64'd0);
    check_eq({tag, "_creq"}, 64'(cdb_req), 64'd0);
    check_eq({tag, "_cval"}, 64'(cdb_valid), 64'd0);
    check_eq({tag, "_cid"}, 64'(cdb_id), 64'd0);
    check_eq({tag, "_cdata"}, cdb_data, 64'd0);
    check_eq({tag, "_free"}, 64'(free_tag_flag), 64'd0);
    check_eq({tag, "_ftag"}, 64'(free_this_tag), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    ready_bus  = 3'b000;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    cdb_grant  = 1'b0;
    m_ptr      = 0;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete load with the given handshake delays (cycles beyond the minimum).
  task automatic do_load(input logic [2:0] rdy, input logic [191:0] addrs, input int ack_dly,
                         input int rv_dly, input int gnt_dly, input logic [63:0] data,
                         input bit late);
    int e;
    logic [63:0] exp_addr;
    logic [63:0] exp_tag;
    e        = model_pick(rdy, m_ptr);
    exp_addr = addrs[e*64 +: 64];
    exp_tag  = 64'(6 + e);

    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_mreq", 64'(mem_req), 64'd0);
    ready_bus = rdy;
    load_addr = addrs;

    for (int i = 0; i <= ack_dly; i++) begin
      @(negedge clk);
      check_eq("req_mreq", 64'(mem_req), 64'd1);
      check_eq("req_addr", mem_addr, exp_addr);
      check_eq("req_creq", 64'(cdb_req), 64'd0);
      mem_ack    = (i == ack_dly);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = rnd64();
      cdb_grant  = 1'($urandom_range(0, 1));
      if (late) begin
        load_addr = {rnd64(), rnd64(), rnd64()};
        ready_bus = 3'($urandom_range(0, 7));
      end
    end

    for (int i = 0; i <= rv_dly; i++) begin
      @(negedge clk);
      check_eq("wait_mreq", 64'(mem_req), 64'd0);
      check_eq("wait_busy", 64'(busy), 64'd1);
      check_eq("wait_creq", 64'(cdb_req), 64'd0);
      mem_ack    = 1'b0;
      mem_rvalid = (i == rv_dly);
      mem_rdata  = (i == rv_dly) ? data : rnd64();
      cdb_grant  = 1'($urandom_range(0, 1));
      if (late) begin
        load_addr = ~addrs;
        ready_bus = 3'b000;
      end
    end

    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      check_eq("cdb_creq", 64'(cdb_req), 64'd1);
      check_eq("cdb_cval", 64'(cdb_valid), 64'd0);
      check_eq("cdb_idle_id", 64'(cdb_id), 64'd0);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = rnd64();
      cdb_grant  = (i == gnt_dly);
    end

    @(negedge clk);
    check_eq("bc_valid", 64'(cdb_valid), 64'd1);
    check_eq("bc_id", 64'(cdb_id), exp_tag);
    check_eq("bc_data", cdb_data, data);
    check_eq("bc_free", 64'(free_tag_flag), 64'd1);
    check_eq("bc_ftag", 64'(free_this_tag), exp_tag);
    check_eq("bc_creq", 64'(cdb_req), 64'd0);
    cdb_grant  = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = rnd64();
    ready_bus  = 3'b000;

    // Exactly one broadcast cycle.
    @(negedge clk);
    check_eq("post_cval", 64'(cdb_valid), 64'd0);
    check_eq("post_free", 64'(free_tag_flag), 64'd0);
    check_eq("post_busy", 64'(busy), 64'd0);
    mem_rvalid = 1'b0;

    m_ptr    = (e + 1) % 3;
    last_tag = 6 + e;
  endtask

  initial begin
    logic [191:0] a;
    int rr_exp [4];
    checks     = 0;
    errors     = 0;
    m_ptr      = 0;
    last_tag   = 0;
    rst_n      = 1'b0;
    ready_bus  = 3'b000;
    load_addr  = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    cdb_grant  = 1'b0;
    rr_exp     = '{6, 7, 8, 6};

    #1;
    check_all_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single load at minimum latency.
    a = {64'h0, 64'h0, 64'h40};
    do_load(3'b100, a, 0, 0, 0, 64'hDEAD, 1'b0);
    check_eq("single_tag", 64'(last_tag), 64'd6);

    // Round-robin from reset with all entries ready.
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      do_load(3'b111, {rnd64(), rnd64(), rnd64()}, 0, 0, 0, rnd64(), 1'b0);
      check_eq("rr_order", 64'(last_tag), 64'(rr_exp[n]));
    end

    // Stalls on every handshake.
    do_load(3'b111, {rnd64(), rnd64(), rnd64()}, 3, 5, 2, rnd64(), 1'b0);

    // Address and ready changes after selection are ignored.
    do_load(3'b010, {rnd64(), 64'h1234_5678_9ABC_DEF0, rnd64()}, 1, 2, 1, rnd64(), 1'b1);
    check_eq("late_tag", 64'(last_tag), 64'd7);

    // Move the pointer off ld_1 so the reset really has to restore it.
    do_load(3'b100, {rnd64(), rnd64(), rnd64()}, 0, 0, 0, rnd64(), 1'b0);

    // Reset in WAIT.
    @(negedge clk);
    ready_bus = 3'b001;
    load_addr = {rnd64(), rnd64(), rnd64()};
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    ready_bus = 3'b000;
    check_eq("mid_wait_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_all_zero("after_rst");
    m_ptr = 0;
    do_load(3'b111, {rnd64(), rnd64(), rnd64()}, 0, 1, 0, rnd64(), 1'b0);
    check_eq("rst_ptr_tag", 64'(last_tag), 64'd6);

    // Idle with nothing ready; handshake inputs toggle and must be ignored.
    ready_bus = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle20_busy", 64'(busy), 64'd0);
      check_eq("idle20_mreq", 64'(mem_req), 64'd0);
      check_eq("idle20_creq", 64'(cdb_req), 64'd0);
      check_eq("idle20_free", 64'(free_tag_flag), 64'd0);
      mem_ack    = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      cdb_grant  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    cdb_grant  = 1'b0;

    // Randomized loads.
    for (int n = 0; n < 40; n++) begin
      do_load(3'($urandom_range(1, 7)), {rnd64(), rnd64(), rnd64()},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), rnd64(), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
